lsu_arb_ctrl: RTL and testbench
===============================

Name: lsu_arb_ctrl

Overview:
- Data-memory access controller for the KIRA RISC-V core.
- Arbitrates between the core load/store port and the PSRF (psrf.lw, opcode 7'h04) word-load port.
- Sequences one outstanding transaction at a time on a req/gnt/rvalid data-memory bus.
- Generates store byte-enables. Aligns and sign/zero-extends load data before returning it to the winning requester.

Parameters:
- AW, 32, address width (data width fixed at 32)
- PSRF_FIRST, 0, requester that wins the first arbitration after reset (0 = core, 1 = psrf)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_valid  in  1  core request valid
- core_ready  out  1  core request accepted this cycle
- core_we  in  1  1 = store, 0 = load
- core_func3  in  3  RV32 load/store funct3
- core_addr  in  AW  byte address
- core_wdata  in  32  store data, right-aligned
- core_rsp_valid  out  1  one-cycle response pulse
- core_rsp_data  out  32  extended load data (0 for stores and errors)
- core_rsp_err  out  1  misaligned access, valid with core_rsp_valid
- psrf_valid  in  1  psrf word-load request
- psrf_ready  out  1  psrf request accepted
- psrf_addr  in  AW  byte address
- psrf_rsp_valid  out  1  one-cycle response pulse
- psrf_rsp_data  out  32  loaded word
- psrf_rsp_err  out  1  misaligned (addr[1:0] != 0)
- dmem_req  out  1  memory request
- dmem_gnt  in  1  memory accepted request
- dmem_we  out  1  write enable
- dmem_be  out  4  byte enables
- dmem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_rvalid  in  1  read data / write ack valid
- dmem_rdata  in  32  read data

Behaviour:
- Reset: all outputs 0; state IDLE; the last-grant register is set so that PSRF_FIRST wins the first tie.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any request is valid, assert ready to exactly one requester.
  - With both valid, use round-robin: the requester not granted last wins.
  - On acceptance, latch owner, we, func3, addr, wdata. For psrf, func3 is fixed to 3'b010 and we = 0.
  - Compute the misalign flag: half-word with addr[0] = 1, or word with addr[1:0] != 0.
  - Misaligned: go to RESP with err = 1 and no memory access.
  - Otherwise: go to REQ.
- REQ:
  - dmem_req = 1 with address, we, be and wdata stable until dmem_gnt.
  - On gnt, go to WAIT. dmem_req deasserts the cycle after gnt.
- WAIT:
  - On dmem_rvalid, register the aligned/extended rdata (loads) or 0 (stores), then go to RESP.
  - rvalid in the same cycle as gnt is not possible; the bus guarantees rvalid is at least 1 cycle after gnt.
- RESP:
  - Owner rsp_valid = 1 for exactly one cycle; the other owner's rsp_valid stays 0. Return to IDLE.
  - No new request is accepted in RESP.
- Latency: with gnt in the first REQ cycle and rvalid 1 cycle later, the accept edge is followed by rsp_valid 3 cycles later. A misaligned access responds 1 cycle after acceptance.
- Byte lanes are little-endian; lane = addr[1:0].
- Stores:
  - SB: be = 4'b0001 << lane; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011 << lane; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads:
  - LB/LBU: byte rdata[8*lane+:8], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: half rdata[16*addr[1]+:16], sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
- Undefined func3 (011, 110, 111 on core port): treated as misaligned; err = 1.
- Simultaneous events:
  - A request arriving while busy is held off (ready = 0). Requesters must keep valid and payload stable.
  - A valid deasserted before acceptance is legal and is simply not granted.
- Reset mid-operation: return to IDLE immediately and drop dmem_req. Any later dmem_rvalid is ignored while in IDLE.

Decomposition:
- lsu_pkg:
  - state enum (IDLE/REQ/WAIT/RESP)
  - owner enum (OWN_CORE/OWN_PSRF)
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - functions be_gen and misaligned
- Sub-module lsu_load_align: combinational; inputs rdata, func3, addr[1:0]; output extended 32-bit word.
- FSM, arbiter and store lane logic stay in lsu_arb_ctrl.

Test Plan:
- Core LB at addr 0x103, dmem_rdata 0x80FF1234 → core_rsp_data 0xFFFFFF80. LBU, same stimulus → 0x00000080.
- Core SH at addr 0x202, wdata 0x0000BEEF → dmem_be 4'b1100, dmem_addr 0x200, dmem_wdata 0xBEEFBEEF, core_rsp_data 0.
- Both core and psrf valid every cycle from reset, PSRF_FIRST = 0 → grants alternate core, psrf, core, psrf. Each rsp_valid pulses once only for its owner.
- psrf load at addr 0x006 → psrf_rsp_err = 1 one cycle after accept, dmem_req never asserted. Core LH at 0x001 → core_rsp_err = 1.
- dmem_gnt withheld 5 cycles → dmem_req, dmem_addr and dmem_be stay stable throughout. rvalid arriving 4 cycles after gnt → single rsp_valid, correct data.
- rst asserted while in WAIT, then dmem_rvalid arrives → no rsp_valid, outputs 0. A new core LW at 0x10 (rdata 0xCAFEF00D) completes normally → core_rsp_data 0xCAFEF00D.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the KIRA data-memory
// access controller (lsu_arb_ctrl) and its load alignment sub-block.
//   - lsu_state_e : controller FSM states
//   - lsu_owner_e : which requester owns the current transaction
//   - F3_*        : RV32 load/store funct3 encodings
//   - be_gen      : byte-enable pattern for a given funct3 and byte lane
//   - misaligned  : access error flag (bad alignment or undefined funct3)
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_PSRF = 1'b1
    } lsu_owner_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic [3:0] be_gen(input logic [2:0] func3,
                                          input logic [1:0] lane);
        logic [3:0] be;
        case (func3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Undefined encodings (011, 110, 111) are reported the same way as a
    // misaligned access so the requester sees a single error path.
    function automatic logic misaligned(input logic [2:0] func3,
                                        input logic [1:0] lane);
        logic mis;
        case (func3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data alignment and extension.
// Ports:
//   rdata [31:0] in  : raw word returned by data memory
//   func3 [2:0]  in  : RV32 load funct3 (LB/LH/LW/LBU/LHU)
//   lane  [1:0]  in  : byte address bits [1:0] of the access
//   word  [31:0] out : selected byte/half, sign- or zero-extended, or full word
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    output logic [31:0] word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lanes: byte n lives in rdata[8n+7:8n]. Halves are picked
    // by addr[1] alone since an aligned half never starts on an odd lane.
    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        word = rdata;
        case (func3)
            F3_B:    word = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   word = {24'd0, byte_sel};
            F3_H:    word = {{16{half_sel[15]}}, half_sel};
            F3_HU:   word = {16'd0, half_sel};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_arb_ctrl.sv
// lsu_arb_ctrl: data-memory access controller for the KIRA RISC-V core.
// Arbitrates (round-robin) between the core load/store port and the PSRF
// word-load port, runs one transaction at a time on a req/gnt/rvalid bus,
// builds store byte-enables / lane data and returns aligned load data.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   core_valid/ready          : core request handshake
//   core_we/func3/addr/wdata  : core request payload (wdata right-aligned)
//   core_rsp_valid/data/err   : core one-cycle response
//   psrf_valid/ready/addr     : PSRF word-load request
//   psrf_rsp_valid/data/err   : PSRF one-cycle response
//   dmem_req/gnt              : memory request handshake
//   dmem_we/be/addr/wdata     : memory request payload (word address)
//   dmem_rvalid/rdata         : memory read data / write acknowledge
module lsu_arb_ctrl
    import lsu_pkg::*;
#(
    parameter int AW         = 32,
    parameter bit PSRF_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_valid,
    output logic          core_ready,
    input  logic          core_we,
    input  logic [2:0]    core_func3,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_rsp_valid,
    output logic [31:0]   core_rsp_data,
    output logic          core_rsp_err,

    input  logic          psrf_valid,
    output logic          psrf_ready,
    input  logic [AW-1:0] psrf_addr,
    output logic          psrf_rsp_valid,
    output logic [31:0]   psrf_rsp_data,
    output logic          psrf_rsp_err,

    output logic          dmem_req,
    input  logic          dmem_gnt,
    output logic          dmem_we,
    output logic [3:0]    dmem_be,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_rvalid,
    input  logic [31:0]   dmem_rdata
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]    state_reg, state_next;
    lsu_owner_e    owner_reg;
    lsu_owner_e    last_reg;       // requester granted most recently
    logic          we_reg;
    logic [2:0]    func3_reg;
    logic [AW-1:0] addr_reg;
    logic [3:0]    be_reg;
    logic [31:0]   wdata_reg;      // already lane-replicated
    logic          err_reg;
    logic [31:0]   rsp_data_reg;

    // ------------------------------------------------------------------
    // Arbitration. The requester not granted last wins a tie; a lone
    // valid always wins. Everything is held off while rst is high so the
    // outputs read 0 from the first reset cycle on.
    // ------------------------------------------------------------------
    logic          active;
    logic          idle;
    logic          pick_psrf;
    logic          accept;
    logic [2:0]    acc_func3;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic          acc_mis;
    logic [31:0]   acc_wdata;

    assign active     = !rst;
    assign idle       = active && (state_reg == IDLE);
    assign pick_psrf  = psrf_valid && (!core_valid || (last_reg == OWN_CORE));
    assign core_ready = idle && core_valid && !pick_psrf;
    assign psrf_ready = idle && pick_psrf;
    assign accept     = core_ready || psrf_ready;

    // PSRF always issues a plain word load.
    assign acc_func3 = pick_psrf ? F3_W : core_func3;
    assign acc_addr  = pick_psrf ? psrf_addr : core_addr;
    assign acc_we    = !pick_psrf && core_we;
    assign acc_mis   = misaligned(acc_func3, acc_addr[1:0]);

    // Store data is replicated across lanes at accept time so the memory
    // side only needs the byte-enables to pick the right bytes.
    always_comb begin
        acc_wdata = 32'd0;
        if (acc_we) begin
            case (acc_func3[1:0])
                2'b00:   acc_wdata = {4{core_wdata[7:0]}};
                2'b01:   acc_wdata = {2{core_wdata[15:0]}};
                default: acc_wdata = core_wdata;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load alignment
    // ------------------------------------------------------------------
    logic [31:0] load_word;

    lsu_load_align u_load_align (
        .rdata (dmem_rdata),
        .func3 (func3_reg),
        .lane  (addr_reg[1:0]),
        .word  (load_word)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = acc_mis ? RESP : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            // Pretend the other side was granted last so PSRF_FIRST wins
            // the first tie.
            last_reg     <= PSRF_FIRST ? OWN_CORE : OWN_PSRF;
            owner_reg    <= OWN_CORE;
            we_reg       <= 1'b0;
            func3_reg    <= 3'd0;
            addr_reg     <= '0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
            rsp_data_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg    <= pick_psrf ? OWN_PSRF : OWN_CORE;
                last_reg     <= pick_psrf ? OWN_PSRF : OWN_CORE;
                we_reg       <= acc_we;
                func3_reg    <= acc_func3;
                addr_reg     <= acc_addr;
                be_reg       <= be_gen(acc_func3, acc_addr[1:0]);
                wdata_reg    <= acc_wdata;
                err_reg      <= acc_mis;
                rsp_data_reg <= 32'd0;
            end
            // Stores and errored accesses return 0; only loads carry data.
            if ((state_reg == WAIT) && dmem_rvalid) begin
                rsp_data_reg <= we_reg ? 32'd0 : load_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-side outputs: driven only while requesting, so the bus sees
    // zeros in every other state.
    // ------------------------------------------------------------------
    logic in_req;
    assign in_req = active && (state_reg == REQ);

    assign dmem_req   = in_req;
    assign dmem_we    = in_req && we_reg;
    assign dmem_be    = in_req ? be_reg : 4'd0;
    assign dmem_addr  = in_req ? {addr_reg[AW-1:2], 2'b00} : '0;
    assign dmem_wdata = (in_req && we_reg) ? wdata_reg : 32'd0;

    // ------------------------------------------------------------------
    // Responses: one cycle in RESP, routed to the owner only.
    // ------------------------------------------------------------------
    logic in_resp;
    assign in_resp = active && (state_reg == RESP);

    assign core_rsp_valid = in_resp && (owner_reg == OWN_CORE);
    assign core_rsp_data  = core_rsp_valid ? rsp_data_reg : 32'd0;
    assign core_rsp_err   = core_rsp_valid && err_reg;

    assign psrf_rsp_valid = in_resp && (owner_reg == OWN_PSRF);
    assign psrf_rsp_data  = psrf_rsp_valid ? rsp_data_reg : 32'd0;
    assign psrf_rsp_err   = psrf_rsp_valid && err_reg;

endmodule

// File: tb/tb_lsu_arb_ctrl.sv
// tb_lsu_arb_ctrl: scoreboard bench for lsu_arb_ctrl. Drivers issue requests,
// a memory responder answers the bus with programmable gnt/rvalid delays,
// and a monitor compares DUT behaviour against a word-array memory model.
module tb_lsu_arb_ctrl;
    import lsu_pkg::*;

    localparam bit PSRF_FIRST = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_ready, core_we;
    logic [2:0]  core_func3;
    logic [31:0] core_addr, core_wdata;
    logic        core_rsp_valid, core_rsp_err;
    logic [31:0] core_rsp_data;
    logic        psrf_valid, psrf_ready;
    logic [31:0] psrf_addr;
    logic        psrf_rsp_valid, psrf_rsp_err;
    logic [31:0] psrf_rsp_data;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    always #5 clk = ~clk;

    lsu_arb_ctrl #(.AW(32), .PSRF_FIRST(PSRF_FIRST)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
        .core_func3(core_func3), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_err(core_rsp_err),
        .psrf_valid(psrf_valid), .psrf_ready(psrf_ready), .psrf_addr(psrf_addr),
        .psrf_rsp_valid(psrf_rsp_valid), .psrf_rsp_data(psrf_rsp_data),
        .psrf_rsp_err(psrf_rsp_err),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        bit          psrf;
        bit          err;
        logic [31:0] data;
        int          acc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } memop_t;

    exp_t        exp_q[$];
    memop_t      mem_q[$];
    int          grant_log[$];
    logic [31:0] mem [int];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit busy = 0;
    int busy_cyc = 0;
    bit last_psrf;
    int rsp_count = 0;
    int last_lat = 0;
    int req_cycles = 0;
    logic [31:0] last_core_data, last_dwdata, last_daddr;
    logic [3:0]  last_be;
    bit          last_core_err, last_psrf_err;

    // Memory responder controls: a negative delay means random 0..3.
    int          gdel = 0, rdel = 0;
    int          gc = -1, rvc = 0;
    bit          pend = 0;
    logic [31:0] pdata;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] memrd(input int w);
        if (mem.exists(w)) return mem[w];
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Reference model: what a request must produce, from the access rules.
    function automatic void model_accept(input bit psrf, input bit we,
                                         input logic [2:0] f3,
                                         input logic [31:0] addr,
                                         input logic [31:0] wd);
        int          sz;
        int          lane;
        bit          bad;
        exp_t        e;
        memop_t      m;
        logic [31:0] w, v;
        lane = int'(addr % 4);
        bad  = 0;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default: begin sz = 1; bad = 1; end
        endcase
        if (addr % sz != 0) bad = 1;
        e.psrf = psrf; e.err = bad; e.acc = cyc; e.data = 32'd0;
        if (!bad) begin
            w      = memrd(int'(addr / 4));
            m.we   = we;
            m.addr = addr - 32'(lane);
            m.be   = 4'(((1 << sz) - 1) << lane);
            if (we) begin
                if (sz == 1)      m.wd = (wd % 256) * 32'h01010101;
                else if (sz == 2) m.wd = (wd % 65536) * 32'h00010001;
                else              m.wd = wd;
                for (int k = 0; k < 4; k++)
                    if (m.be[k]) w[8*k +: 8] = m.wd[8*k +: 8];
                mem[int'(addr / 4)] = w;
            end else begin
                m.wd = 32'd0;
                if (sz == 4) v = w;
                else begin
                    v = (w >> (8 * lane)) % (32'd1 << (8 * sz));
                    if (f3[2] == 1'b0 && v >= (32'd1 << (8 * sz - 1)))
                        v = v - (32'd1 << (8 * sz));
                end
                e.data = v;
            end
            mem_q.push_back(m);
        end
        exp_q.push_back(e);
        grant_log.push_back(psrf ? 1 : 0);
        busy       = 1;
        last_psrf  = psrf;
        req_cycles = 0;
    endfunction

    // Memory responder: drives gnt/rvalid just after the clock edge.
    initial begin
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        forever begin
            @(posedge clk); #2;
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (rst) gc = -1;
            if (pend) begin
                if (rvc == 0) begin
                    dmem_rvalid = 1; dmem_rdata = pdata; pend = 0;
                end else rvc--;
            end else if (dmem_req) begin
                if (gc < 0) gc = (gdel < 0) ? $urandom_range(0, 3) : gdel;
                if (gc == 0) begin
                    dmem_gnt = 1;
                    pend     = 1;
                    rvc      = (rdel < 0) ? $urandom_range(0, 3) : rdel;
                    pdata    = dmem_we ? $urandom : memrd(int'(dmem_addr >> 2));
                    gc       = -1;
                end else gc--;
            end
        end
    end

    // Monitor / scoreboard: samples on the falling edge.
    initial begin
        logic [1:0]  exp_rdy;
        exp_t        e;
        memop_t      m;
        logic [31:0] got_d;
        bit          got_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_ctrl", 32'({core_ready, psrf_ready, core_rsp_valid, psrf_rsp_valid,
                                      core_rsp_err, psrf_rsp_err, dmem_req, dmem_we}), 32'd0);
                chk("reset_data", core_rsp_data | psrf_rsp_data | dmem_wdata | dmem_addr
                                  | 32'(dmem_be), 32'd0);
                exp_q.delete(); mem_q.delete();
                busy = 0; busy_cyc = 0; last_psrf = !PSRF_FIRST;
            end else begin
                if (busy) chk("ready_while_busy", 32'({core_ready, psrf_ready}), 32'd0);
                else begin
                    exp_rdy = 2'b00;
                    if (core_valid && psrf_valid) exp_rdy = last_psrf ? 2'b10 : 2'b01;
                    else if (core_valid)          exp_rdy = 2'b10;
                    else if (psrf_valid)          exp_rdy = 2'b01;
                    chk("arbitration", 32'({core_ready, psrf_ready}), 32'(exp_rdy));
                end

                if (dmem_req) begin
                    req_cycles++;
                    if (mem_q.size() == 0) chk("dmem_req_unexpected", 32'(dmem_req), 32'd0);
                    else begin
                        m = mem_q[0];
                        chk("dmem_we", 32'(dmem_we), 32'(m.we));
                        chk("dmem_addr", dmem_addr, m.addr);
                        if (m.we) begin
                            chk("dmem_be", 32'(dmem_be), 32'(m.be));
                            chk("dmem_wdata", dmem_wdata, m.wd);
                            last_be = dmem_be; last_dwdata = dmem_wdata; last_daddr = dmem_addr;
                        end
                        if (dmem_gnt) void'(mem_q.pop_front());
                    end
                end

                if (core_rsp_valid || psrf_rsp_valid) begin
                    rsp_count++;
                    if (exp_q.size() == 0)
                        chk("rsp_unexpected", 32'({core_rsp_valid, psrf_rsp_valid}), 32'd0);
                    else begin
                        e     = exp_q.pop_front();
                        got_d = e.psrf ? psrf_rsp_data : core_rsp_data;
                        got_e = e.psrf ? psrf_rsp_err : core_rsp_err;
                        last_lat = cyc - e.acc;
                        chk("rsp_owner", 32'({core_rsp_valid, psrf_rsp_valid}), e.psrf ? 32'd1 : 32'd2);
                        chk("rsp_data", got_d, e.data);
                        chk("rsp_err", 32'(got_e), 32'(e.err));
                        chk("other_port_data", e.psrf ? core_rsp_data : psrf_rsp_data, 32'd0);
                        chk("mem_ops_drained", 32'(mem_q.size()), 32'd0);
                        if (e.err) chk("misalign_latency", 32'(last_lat), 32'd1);
                        if (e.psrf) last_psrf_err = got_e;
                        else begin last_core_data = got_d; last_core_err = got_e; end
                        $display("[TB] %s rsp data=0x%08h err=%0d lat=%0d",
                                 e.psrf ? "psrf" : "core", got_d, got_e, last_lat);
                    end
                    busy = 0;
                end

                if (core_valid && core_ready)
                    model_accept(0, core_we, core_func3, core_addr, core_wdata);
                else if (psrf_valid && psrf_ready)
                    model_accept(1, 0, F3_W, psrf_addr, 32'd0);

                if (busy) begin
                    busy_cyc++;
                    if (busy_cyc > 200) begin
                        chk("txn_timeout", 32'(busy_cyc), 32'd0);
                        busy = 0; exp_q.delete(); mem_q.delete();
                    end
                end else busy_cyc = 0;
            end
        end
    end

    // Drive one request; withdraw it after max_wait cycles if not accepted.
    task automatic issue(input bit psrf, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int max_wait, input bit must);
        bit acc = 0;
        if (psrf) begin psrf_valid = 1; psrf_addr = addr; end
        else begin
            core_valid = 1; core_we = we; core_func3 = f3;
            core_addr = addr; core_wdata = wd;
        end
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            if (psrf ? psrf_ready : core_ready) acc = 1;
            @(posedge clk); #2;
        end
        if (psrf) psrf_valid = 0; else core_valid = 0;
        if (must && !acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin @(posedge clk); n++; end
        chk("idle_wait", 32'(busy), 32'd0);
        @(posedge clk); #2;
    endtask

    initial begin
        int n, rc;
        rst = 1;
        core_valid = 0; core_we = 0; core_func3 = 0; core_addr = 0; core_wdata = 0;
        psrf_valid = 0; psrf_addr = 0;
        repeat (3) @(posedge clk); #2;
        rst = 0;

        // Both requesters hammering from reset: grants must alternate.
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 0, F3_W, 32'h100 + 32'(4*i), 0, 100, 1); end
            begin for (int i = 0; i < 4; i++) issue(1, 0, F3_W, 32'h180 + 32'(4*i), 0, 100, 1); end
        join
        wait_idle();
        for (int i = 0; i < 4; i++)
            chk("grant_order", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'd7, 32'(i % 2));

        // Byte loads with sign/zero extension, fastest bus timing.
        mem[32'h103 >> 2] = 32'h80FF1234;
        issue(0, 0, F3_B, 32'h103, 0, 50, 1);  wait_idle();
        chk("lb_data", last_core_data, 32'hFFFFFF80);
        chk("lb_latency", 32'(last_lat), 32'd3);
        issue(0, 0, F3_BU, 32'h103, 0, 50, 1); wait_idle();
        chk("lbu_data", last_core_data, 32'h00000080);

        // Halfword store in the upper lanes.
        issue(0, 1, F3_H, 32'h202, 32'h0000BEEF, 50, 1); wait_idle();
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_addr", last_daddr, 32'h200);
        chk("sh_wdata", last_dwdata, 32'hBEEFBEEF);
        chk("sh_rsp_data", last_core_data, 32'd0);

        // Misaligned accesses never touch memory.
        issue(1, 0, F3_W, 32'h006, 0, 50, 1); wait_idle();
        chk("psrf_misalign_err", 32'(last_psrf_err), 32'd1);
        issue(0, 0, F3_H, 32'h001, 0, 50, 1); wait_idle();
        chk("core_misalign_err", 32'(last_core_err), 32'd1);

        // Grant withheld 5 cycles, rvalid 4 cycles after grant.
        gdel = 5; rdel = 3;
        issue(0, 0, F3_H, 32'h302, 0, 50, 1); wait_idle();
        chk("stall_req_cycles", 32'(req_cycles), 32'd6);
        chk("stall_latency", 32'(last_lat), 32'd11);

        // Reset while waiting for read data; the late rvalid must be ignored.
        gdel = 0; rdel = 6;
        issue(0, 0, F3_W, 32'h40, 0, 50, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!dmem_gnt && n < 20);
        chk("reset_test_gnt_seen", 32'(dmem_gnt), 32'd1);
        @(posedge clk); #2; rst = 1;
        @(posedge clk); #2; rst = 0;
        rc = rsp_count;
        repeat (12) @(posedge clk); #2;
        chk("no_rsp_after_reset", 32'(rsp_count - rc), 32'd0);
        rdel = 0;
        mem[32'h10 >> 2] = 32'hCAFEF00D;
        issue(0, 0, F3_W, 32'h10, 0, 50, 1); wait_idle();
        chk("lw_after_reset", last_core_data, 32'hCAFEF00D);

        // Randomized mixed traffic with random bus delays.
        gdel = -1; rdel = -1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] a;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
                    a = 32'h100 + 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 9) == 0)
                        issue(0, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, $urandom, 1, 0);
                    else
                        issue(0, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, $urandom, 300, 1);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                    a = 32'h100 + 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 4) != 0) a = a & ~32'd3;
                    issue(1, 0, F3_W, a, 0, 300, 1);
                end
            end
        join
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
